// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - write-back arbiter merging ALU results and in-order load returns
// Optional same-cycle bypass ports are built when WB_BYPASS_EN is defined.
module wb_arbiter #(
    parameter int LDQ_DEPTH = 4,
    parameter int LDQ_AW    = 2
) (
    input  logic        clk,
    input  logic        rstd,
    input  logic        alu_valid,
    output logic        alu_ready,
    input  logic [4:0]  alu_wa,
    input  logic [31:0] alu_result,
    input  logic        ld_issue,
    output logic        ld_issue_ready,
    input  logic [4:0]  ld_issue_wa,
    input  logic [2:0]  ld_issue_funct3,
    input  logic [1:0]  ld_issue_addr_lo,
    input  logic        ld_rvalid,
    input  logic [31:0] ld_rdata,
    output logic [31:0] wr,
    output logic [4:0]  wa,
    output logic        wren,
    output logic [31:0] busy,
    output logic        ldq_err
`ifdef WB_BYPASS_EN
    ,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic        byp1_hit,
    output logic [31:0] byp1_data,
    output logic        byp2_hit,
    output logic [31:0] byp2_data
`endif
);

    localparam logic [LDQ_AW:0] FULL_CNT = (LDQ_AW+1)'(LDQ_DEPTH);

    logic [4:0]        ldq_wa_q [LDQ_DEPTH];
    logic [4:0]        ldq_wa_d [LDQ_DEPTH];
    logic [2:0]        ldq_f3_q [LDQ_DEPTH];
    logic [2:0]        ldq_f3_d [LDQ_DEPTH];
    logic [1:0]        ldq_al_q [LDQ_DEPTH];
    logic [1:0]        ldq_al_d [LDQ_DEPTH];
    logic [LDQ_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [LDQ_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LDQ_AW:0]   count_q, count_d;

    logic              skid_valid_q, skid_valid_d;
    logic [4:0]        skid_wa_q, skid_wa_d;
    logic [31:0]       skid_data_q, skid_data_d;

    logic [31:0]       wr_q, wr_d;
    logic [4:0]        wa_q, wa_d;
    logic              wren_q, wren_d;
    logic [31:0]       busy_q, busy_d;
    logic              ldq_err_q, ldq_err_d;

    logic              alu_fire;
    logic              issue_fire;
    logic              ld_pop;
    logic [4:0]        head_wa;
    logic [2:0]        head_f3;
    logic [1:0]        head_al;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [31:0]       ld_ext;

    always_comb begin
        alu_ready      = ~skid_valid_q;
        ld_issue_ready = (count_q != FULL_CNT);
        alu_fire       = alu_valid & alu_ready;
        issue_fire     = ld_issue & ld_issue_ready;
        ld_pop         = ld_rvalid & (count_q != '0);
    end

    // Little-endian lane extraction for the head load's data.
    always_comb begin
        head_wa = ldq_wa_q[rd_ptr_q];
        head_f3 = ldq_f3_q[rd_ptr_q];
        head_al = ldq_al_q[rd_ptr_q];
        case (head_al)
            2'd0:    ld_byte = ld_rdata[7:0];
            2'd1:    ld_byte = ld_rdata[15:8];
            2'd2:    ld_byte = ld_rdata[23:16];
            default: ld_byte = ld_rdata[31:24];
        endcase
        ld_half = head_al[1] ? ld_rdata[31:16] : ld_rdata[15:0];
        case (head_f3)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_ext = {24'd0, ld_byte};
            3'b101:  ld_ext = {16'd0, ld_half};
            default: ld_ext = ld_rdata;
        endcase
    end

    always_comb begin
        wr_d         = wr_q;
        wa_d         = wa_q;
        wren_d       = 1'b0;
        skid_valid_d = skid_valid_q;
        skid_wa_d    = skid_wa_q;
        skid_data_d  = skid_data_q;
        busy_d       = busy_q;
        ldq_err_d    = ldq_err_q | (ld_rvalid & ~ld_pop);
        ldq_wa_d     = ldq_wa_q;
        ldq_f3_d     = ldq_f3_q;
        ldq_al_d     = ldq_al_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;

        // A return owns the port; an ALU result accepted alongside it parks in the skid.
        if (ld_rvalid) begin
            if (ld_pop) begin
                wr_d            = ld_ext;
                wa_d            = head_wa;
                wren_d          = (head_wa != 5'd0);
                busy_d[head_wa] = 1'b0;
                rd_ptr_d        = rd_ptr_q + 1'b1;
            end
            if (alu_fire) begin
                skid_valid_d = 1'b1;
                skid_wa_d    = alu_wa;
                skid_data_d  = alu_result;
            end
        end else if (skid_valid_q) begin
            wr_d         = skid_data_q;
            wa_d         = skid_wa_q;
            wren_d       = (skid_wa_q != 5'd0);
            skid_valid_d = 1'b0;
        end else if (alu_fire) begin
            wr_d   = alu_result;
            wa_d   = alu_wa;
            wren_d = (alu_wa != 5'd0);
        end

        // Set after clear so a newer load to the same register keeps it busy.
        if (issue_fire) begin
            ldq_wa_d[wr_ptr_q] = ld_issue_wa;
            ldq_f3_d[wr_ptr_q] = ld_issue_funct3;
            ldq_al_d[wr_ptr_q] = ld_issue_addr_lo;
            wr_ptr_d           = wr_ptr_q + 1'b1;
            if (ld_issue_wa != 5'd0) begin
                busy_d[ld_issue_wa] = 1'b1;
            end
        end
        busy_d[0] = 1'b0;

        case ({issue_fire, ld_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rstd) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            skid_valid_q <= 1'b0;
            skid_wa_q    <= 5'd0;
            skid_data_q  <= 32'd0;
            wr_q         <= 32'd0;
            wa_q         <= 5'd0;
            wren_q       <= 1'b0;
            busy_q       <= 32'd0;
            ldq_err_q    <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            skid_valid_q <= skid_valid_d;
            skid_wa_q    <= skid_wa_d;
            skid_data_q  <= skid_data_d;
            wr_q         <= wr_d;
            wa_q         <= wa_d;
            wren_q       <= wren_d;
            busy_q       <= busy_d;
            ldq_err_q    <= ldq_err_d;
        end
    end

    // Entry payloads need no reset: the count alone says which slots are live.
    always_ff @(posedge clk) begin
        ldq_wa_q <= ldq_wa_d;
        ldq_f3_q <= ldq_f3_d;
        ldq_al_q <= ldq_al_d;
    end

    assign wr      = wr_q;
    assign wa      = wa_q;
    assign wren    = wren_q;
    assign busy    = busy_q;
    assign ldq_err = ldq_err_q;

`ifdef WB_BYPASS_EN
    assign byp1_hit  = wren_q & (wa_q == ra1) & (ra1 != 5'd0);
    assign byp1_data = wr_q;
    assign byp2_hit  = wren_q & (wa_q == ra2) & (ra2 != 5'd0);
    assign byp2_data = wr_q;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - scoreboard bench for wb_arbiter with a queue-based reference model
module tb_wb_arbiter;
    localparam int DEPTH = 4;

    typedef struct {
        logic       rst;
        logic       av;
        logic [4:0] awa;
        logic [31:0] ares;
        logic       li;
        logic [4:0] lwa;
        logic [2:0] lf3;
        logic [1:0] lal;
        logic       lrv;
        logic [31:0] lrd;
    } stim_t;

    typedef struct {
        int          cyc;
        logic [4:0]  wa;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        logic [4:0] wa;
        logic [2:0] f3;
        logic [1:0] al;
    } pend_t;

    logic        clk = 1'b0;
    logic        rstd = 1'b1;
    logic        alu_valid = 1'b0;
    logic        alu_ready;
    logic [4:0]  alu_wa = '0;
    logic [31:0] alu_result = '0;
    logic        ld_issue = 1'b0;
    logic        ld_issue_ready;
    logic [4:0]  ld_issue_wa = '0;
    logic [2:0]  ld_issue_funct3 = '0;
    logic [1:0]  ld_issue_addr_lo = '0;
    logic        ld_rvalid = 1'b0;
    logic [31:0] ld_rdata = '0;
    logic [31:0] wr;
    logic [4:0]  wa;
    logic        wren;
    logic [31:0] busy;
    logic        ldq_err;
`ifdef WB_BYPASS_EN
    logic [4:0]  ra1 = '0;
    logic [4:0]  ra2 = '0;
    logic        byp1_hit;
    logic [31:0] byp1_data;
    logic        byp2_hit;
    logic [31:0] byp2_data;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    exp_t        exp_q[$];
    pend_t       mq[$];
    logic        held_v  = 1'b0;
    logic [4:0]  held_wa = '0;
    logic [31:0] held_d  = '0;
    logic [31:0] m_busy  = '0;
    logic        m_err   = 1'b0;

    wb_arbiter #(.LDQ_DEPTH(DEPTH), .LDQ_AW(2)) dut (
        .clk(clk), .rstd(rstd),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_wa(alu_wa), .alu_result(alu_result),
        .ld_issue(ld_issue), .ld_issue_ready(ld_issue_ready), .ld_issue_wa(ld_issue_wa),
        .ld_issue_funct3(ld_issue_funct3), .ld_issue_addr_lo(ld_issue_addr_lo),
        .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
        .wr(wr), .wa(wa), .wren(wren), .busy(busy), .ldq_err(ldq_err)
`ifdef WB_BYPASS_EN
        , .ra1(ra1), .ra2(ra2), .byp1_hit(byp1_hit), .byp1_data(byp1_data),
        .byp2_hit(byp2_hit), .byp2_data(byp2_data)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] ref_ext(logic [31:0] d, logic [2:0] f3, logic [1:0] al);
        logic [31:0] b;
        logic [31:0] h;
        b = (d >> (8 * al)) & 32'hFF;
        h = (d >> (16 * (al / 2))) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 32'd128) ? b - 32'd256 : b;
            3'd1:    return (h >= 32'd32768) ? h - 32'd65536 : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return d;
        endcase
    endfunction

    function automatic void push_exp(int c, logic [4:0] w, logic [31:0] d);
        exp_t e;
        if (w != 5'd0) begin
            e.cyc = c; e.wa = w; e.data = d;
            exp_q.push_back(e);
        end
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s = '{default: '0};
        return s;
    endfunction

    // Drive one cycle of stimulus; the model decides what write appears one cycle later.
    task automatic step(input stim_t s);
        pend_t h;
        pend_t n;
        logic  full;
        logic  acc;
        @(negedge clk);
        chk("alu_ready", 32'(alu_ready), 32'(!held_v));
        chk("ld_issue_ready", 32'(ld_issue_ready), 32'(mq.size() != DEPTH));
        chk("busy", busy, m_busy);
        chk("ldq_err", 32'(ldq_err), 32'(m_err));
        if (s.rst) begin
            mq.delete();
            held_v = 1'b0;
            m_busy = '0;
            m_err  = 1'b0;
        end else begin
            full = (mq.size() == DEPTH);
            acc  = s.av && !held_v;
            if (s.lrv) begin
                if (mq.size() > 0) begin
                    h = mq.pop_front();
                    m_busy[h.wa] = 1'b0;
                    push_exp(cyc + 1, h.wa, ref_ext(s.lrd, h.f3, h.al));
                end else begin
                    m_err = 1'b1;
                end
                if (acc) begin
                    held_v = 1'b1; held_wa = s.awa; held_d = s.ares;
                end
            end else if (held_v) begin
                push_exp(cyc + 1, held_wa, held_d);
                held_v = 1'b0;
            end else if (acc) begin
                push_exp(cyc + 1, s.awa, s.ares);
            end
            if (s.li && !full) begin
                n.wa = s.lwa; n.f3 = s.lf3; n.al = s.lal;
                mq.push_back(n);
                if (s.lwa != 5'd0) m_busy[s.lwa] = 1'b1;
            end
            m_busy[0] = 1'b0;
        end
        rstd             = s.rst;
        alu_valid        = s.av;
        alu_wa           = s.awa;
        alu_result       = s.ares;
        ld_issue         = s.li;
        ld_issue_wa      = s.lwa;
        ld_issue_funct3  = s.lf3;
        ld_issue_addr_lo = s.lal;
        ld_rvalid        = s.lrv;
        ld_rdata         = s.lrd;
    endtask

    // Monitor: every presented write must match the head of the scoreboard at its cycle.
    always @(negedge clk) begin
        exp_t e;
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            e = exp_q.pop_front();
            n_checks++; n_fail++;
            $display("FAIL write_missing: got none expected wa=%0d wr=%h at cycle %0d", e.wa, e.data, e.cyc);
        end
        if (wren) begin
            n_checks++;
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                e = exp_q.pop_front();
                if (wa !== e.wa || wr !== e.data) begin
                    n_fail++;
                    $display("FAIL write_data: got wa=%0d wr=%h expected wa=%0d wr=%h (cycle %0d)", wa, wr, e.wa, e.data, cyc);
                end
            end else begin
                n_fail++;
                $display("FAIL write_unexpected: got wa=%0d wr=%h expected no write (cycle %0d)", wa, wr, cyc);
            end
        end else if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            e = exp_q.pop_front();
            n_checks++; n_fail++;
            $display("FAIL write_missing: got wren=0 expected wa=%0d wr=%h (cycle %0d)", e.wa, e.data, cyc);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected test end");
        $fatal(1, "watchdog");
    end

    initial begin
        stim_t s;
        // Reset with random inputs
        for (int i = 0; i < 2; i++) begin
            s = '{1'b1, 1'($urandom), 5'($urandom), $urandom, 1'($urandom), 5'($urandom),
                  3'($urandom), 2'($urandom), 1'($urandom), $urandom};
            step(s);
        end
        step(idle());
        chk("rst_wren", 32'(wren), 32'd0);
        chk("rst_busy", busy, 32'd0);
        chk("rst_alu_ready", 32'(alu_ready), 32'd1);
        chk("rst_ldq_ready", 32'(ld_issue_ready), 32'd1);

        // ALU only
        s = idle(); s.av = 1'b1; s.awa = 5'd5; s.ares = 32'h1234;
        step(s);
        step(idle());
        chk("alu_wren", 32'(wren), 32'd1);
        chk("alu_wa", 32'(wa), 32'd5);
        chk("alu_wr", wr, 32'h1234);
        s.awa = 5'd0;
        step(s);
        step(idle());
        chk("alu_x0_wren", 32'(wren), 32'd0);

        // Load extension: lb lane 3 then lhu lane 2
        s = idle(); s.li = 1'b1; s.lwa = 5'd7; s.lf3 = 3'b000; s.lal = 2'd3;
        step(s);
        step(idle());
        chk("busy7_set", 32'(busy[7]), 32'd1);
        s = idle(); s.lrv = 1'b1; s.lrd = 32'h80FF_0102;
        step(s);
        step(idle());
        chk("lb_wr", wr, 32'hFFFF_FF80);
        chk("busy7_clr", 32'(busy[7]), 32'd0);
        s = idle(); s.li = 1'b1; s.lwa = 5'd7; s.lf3 = 3'b101; s.lal = 2'd2;
        step(s);
        s = idle(); s.lrv = 1'b1; s.lrd = 32'h80FF_0102;
        step(s);
        step(idle());
        chk("lhu_wr", wr, 32'h0000_80FF);

        // Conflict: load return wins, ALU result waits in the skid
        s = idle(); s.li = 1'b1; s.lwa = 5'd4; s.lf3 = 3'b010;
        step(s);
        s = idle(); s.av = 1'b1; s.awa = 5'd3; s.ares = 32'hAA; s.lrv = 1'b1; s.lrd = 32'h55;
        step(s);
        step(idle());
        chk("conf_ld_wa", 32'(wa), 32'd4);
        chk("conf_ld_wr", wr, 32'h55);
        chk("conf_alu_ready", 32'(alu_ready), 32'd0);
        step(idle());
        chk("conf_alu_wa", 32'(wa), 32'd3);
        chk("conf_alu_wr", wr, 32'hAA);

        // Queue full, dropped fifth issue, wrap, empty-return error
        for (int i = 0; i < 5; i++) begin
            s = idle(); s.li = 1'b1; s.lwa = 5'(10 + i); s.lf3 = 3'b010;
            step(s);
        end
        chk("ldq_full", 32'(ld_issue_ready), 32'd0);
        for (int i = 0; i < 4; i++) begin
            s = idle(); s.lrv = 1'b1; s.lrd = 32'(32'h100 + i);
            step(s);
        end
        s = idle(); s.lrv = 1'b1; s.lrd = 32'hBAD;
        step(s);
        step(idle());
        chk("err_wren", 32'(wren), 32'd0);
        chk("err_sticky", 32'(ldq_err), 32'd1);

`ifdef WB_BYPASS_EN
        s = idle(); s.av = 1'b1; s.awa = 5'd9; s.ares = 32'hDEAD;
        step(s);
        step(idle());
        ra1 = 5'd9; ra2 = 5'd0;
        #1;
        chk("byp1_hit", 32'(byp1_hit), 32'd1);
        chk("byp1_data", byp1_data, 32'hDEAD);
        chk("byp2_hit", 32'(byp2_hit), 32'd0);
`endif

        // Randomized traffic with occasional mid-operation reset
        s = idle(); s.rst = 1'b1;
        step(s);
        for (int i = 0; i < 3000; i++) begin
            s.rst  = ($urandom_range(0, 199) == 0);
            s.av   = 1'($urandom_range(0, 1));
            s.awa  = 5'($urandom_range(0, 31));
            s.ares = $urandom;
            s.li   = ($urandom_range(0, 9) < 4);
            s.lwa  = 5'($urandom_range(0, 31));
            s.lf3  = 3'($urandom_range(0, 7));
            s.lal  = 2'($urandom_range(0, 3));
            s.lrv  = (mq.size() > 0) && ($urandom_range(0, 9) < 4);
            s.lrd  = $urandom;
            step(s);
        end
        for (int i = 0; i < 8; i++) step(idle());
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
